blk_hit_trk_md: RTL and testbench

//  Registered, parametrised hit detector for the MESI cache data path.
//  - Compares per-way tag-match vector against the proc command; drives registered hit flag and encoded hit way.
//  - Flags multi-way hits (sticky) and illegal rd+wr commands.
//  - Optionally keeps saturating rd/wr hit/miss performance counters.
//  - Sits between the tag-compare logic and the cache controller FSM of each L1/L2 instance.

---
 rtl/blk_hit_pkg.sv | 28 ++
 rtl/blk_hit_trk_md_if.sv | 49 ++++
 rtl/blk_hit_sat_cnt.sv | 26 ++
 rtl/blk_hit_trk_md.sv | 115 +++++++++++
 tb/tb_blk_hit_trk_md.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/blk_hit_pkg.sv
// Shared types and helpers for the blk_hit_trk_md hit detector.
// The default associativity comes from ASSOC_LV2, which defaults to 4.
`ifndef ASSOC_LV2
`define ASSOC_LV2 4
`endif

package blk_hit_pkg;

    localparam int ASSOC_DFLT = `ASSOC_LV2;
    localparam int CNT_W_DFLT = 16;
    localparam int MAX_ASSOC  = 64;

    typedef enum logic [1:0] {HIT_RD, HIT_WR, MISS_RD, MISS_WR} hit_evt_e;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic int unsigned onehot_lsb_idx(input logic [MAX_ASSOC-1:0] vec);
        onehot_lsb_idx = 0;
        for (int i = MAX_ASSOC - 1; i >= 0; i--) begin
            if (vec[i]) onehot_lsb_idx = int'(i);
        end
    endfunction

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic popcnt_gt1(input logic [MAX_ASSOC-1:0] vec);
        return |(vec & (vec - MAX_ASSOC'(1)));
    endfunction

endpackage

// File: rtl/blk_hit_trk_md_if.sv
// Request/result bundle between the tag-compare side and the hit detector.
// Counter signals exist only when BLK_HIT_PERF_CNT_EN is defined.
interface blk_hit_trk_md_if
    import blk_hit_pkg::*;
#(
    parameter int ASSOC = ASSOC_DFLT,
    parameter int CNT_W = CNT_W_DFLT
);
    localparam int WAY_W = (ASSOC > 1) ? $clog2(ASSOC) : 1;

    logic             cmd_rd;
    logic             cmd_wr;
    logic [ASSOC-1:0] access_blk_proc;
    logic             err_clr;
    logic             blk_hit_proc;
    logic [WAY_W-1:0] hit_way;
    logic             res_vld;
    logic             multi_hit_err;
    logic             cmd_err;

`ifdef BLK_HIT_PERF_CNT_EN
    logic             cnt_clr;
    logic [CNT_W-1:0] rd_hit_cnt;
    logic [CNT_W-1:0] rd_miss_cnt;
    logic [CNT_W-1:0] wr_hit_cnt;
    logic [CNT_W-1:0] wr_miss_cnt;

    modport master (
        output cmd_rd, cmd_wr, access_blk_proc, err_clr, cnt_clr,
        input  blk_hit_proc, hit_way, res_vld, multi_hit_err, cmd_err,
        input  rd_hit_cnt, rd_miss_cnt, wr_hit_cnt, wr_miss_cnt
    );
    modport slave (
        input  cmd_rd, cmd_wr, access_blk_proc, err_clr, cnt_clr,
        output blk_hit_proc, hit_way, res_vld, multi_hit_err, cmd_err,
        output rd_hit_cnt, rd_miss_cnt, wr_hit_cnt, wr_miss_cnt
    );
`else
    modport master (
        output cmd_rd, cmd_wr, access_blk_proc, err_clr,
        input  blk_hit_proc, hit_way, res_vld, multi_hit_err, cmd_err
    );
    modport slave (
        input  cmd_rd, cmd_wr, access_blk_proc, err_clr,
        output blk_hit_proc, hit_way, res_vld, multi_hit_err, cmd_err
    );
`endif

endinterface

// File: rtl/blk_hit_sat_cnt.sv
// Saturating up-counter: sticks at all-ones, clear has priority over increment.
module blk_hit_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;

    // NOTE: clocked state uses <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/blk_hit_trk_md.sv
// Registered per-way hit detector with sticky error flags for the MESI data path.
// Define BLK_HIT_PERF_CNT_EN to add saturating rd/wr hit/miss counters.
module blk_hit_trk_md
    import blk_hit_pkg::*;
#(
    parameter int ASSOC = ASSOC_DFLT,
    parameter int CNT_W = CNT_W_DFLT
) (
    input logic              clk,
    input logic              rst,
    blk_hit_trk_md_if.slave  hit_if
);
    localparam int WAY_W = (ASSOC > 1) ? $clog2(ASSOC) : 1;

    logic             w_cmd_act;
    logic             w_hit;
    logic             w_multi;
    logic             w_new_req;
    logic             w_req_wr;
    logic [WAY_W-1:0] w_way;

    logic             r_cmd_act_q;
    logic             r_hit;
    logic [WAY_W-1:0] r_hit_way;
    logic             r_res_vld;
    logic             r_req_wr;
    logic             r_multi_hit_err;
    logic             r_cmd_err;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_cmd_act = hit_if.cmd_rd | hit_if.cmd_wr;
        w_hit     = w_cmd_act && (|hit_if.access_blk_proc);
        w_multi   = w_cmd_act && popcnt_gt1(MAX_ASSOC'(hit_if.access_blk_proc));
        w_new_req = w_cmd_act && !r_cmd_act_q;
        // A combined rd+wr command is counted as a read.
        w_req_wr  = hit_if.cmd_wr && !hit_if.cmd_rd;
        w_way     = '0;
        if (w_hit) begin
            w_way = WAY_W'(onehot_lsb_idx(MAX_ASSOC'(hit_if.access_blk_proc)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd_act_q <= 1'b0;
            r_hit       <= 1'b0;
            r_hit_way   <= '0;
            r_res_vld   <= 1'b0;
            r_req_wr    <= 1'b0;
        end else begin
            r_cmd_act_q <= w_cmd_act;
            r_hit       <= w_hit;
            r_hit_way   <= w_way;
            r_res_vld   <= w_new_req;
            r_req_wr    <= w_req_wr;
        end
    end

    // Sticky errors: a fresh error outranks a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_multi_hit_err <= 1'b0;
            r_cmd_err       <= 1'b0;
        end else begin
            if (w_multi) begin
                r_multi_hit_err <= 1'b1;
            end else if (hit_if.err_clr) begin
                r_multi_hit_err <= 1'b0;
            end
            if (hit_if.cmd_rd && hit_if.cmd_wr) begin
                r_cmd_err <= 1'b1;
            end else if (hit_if.err_clr) begin
                r_cmd_err <= 1'b0;
            end
        end
    end

    assign hit_if.blk_hit_proc  = r_hit;
    assign hit_if.hit_way       = r_hit_way;
    assign hit_if.res_vld       = r_res_vld;
    assign hit_if.multi_hit_err = r_multi_hit_err;
    assign hit_if.cmd_err       = r_cmd_err;

`ifdef BLK_HIT_PERF_CNT_EN
    hit_evt_e   w_evt;
    logic [3:0] w_inc;

    // Classify the registered result while res_vld is high.
    always_comb begin
        unique case ({r_req_wr, r_hit})
            2'b01:   w_evt = HIT_RD;
            2'b11:   w_evt = HIT_WR;
            2'b10:   w_evt = MISS_WR;
            default: w_evt = MISS_RD;
        endcase
        w_inc        = '0;
        w_inc[w_evt] = r_res_vld;
    end

    blk_hit_sat_cnt #(.CNT_W(CNT_W)) u_rd_hit_cnt (
        .clk(clk), .rst(rst), .i_inc(w_inc[HIT_RD]), .i_clr(hit_if.cnt_clr), .o_cnt(hit_if.rd_hit_cnt)
    );
    blk_hit_sat_cnt #(.CNT_W(CNT_W)) u_wr_hit_cnt (
        .clk(clk), .rst(rst), .i_inc(w_inc[HIT_WR]), .i_clr(hit_if.cnt_clr), .o_cnt(hit_if.wr_hit_cnt)
    );
    blk_hit_sat_cnt #(.CNT_W(CNT_W)) u_rd_miss_cnt (
        .clk(clk), .rst(rst), .i_inc(w_inc[MISS_RD]), .i_clr(hit_if.cnt_clr), .o_cnt(hit_if.rd_miss_cnt)
    );
    blk_hit_sat_cnt #(.CNT_W(CNT_W)) u_wr_miss_cnt (
        .clk(clk), .rst(rst), .i_inc(w_inc[MISS_WR]), .i_clr(hit_if.cnt_clr), .o_cnt(hit_if.wr_miss_cnt)
    );
`endif

endmodule

// File: tb/tb_blk_hit_trk_md.sv
// Directed and random bench for blk_hit_trk_md against a cycle-level reference model.
// Counter checks are active when BLK_HIT_PERF_CNT_EN is defined.
module tb_blk_hit_trk_md;
    localparam int ASSOC   = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    blk_hit_trk_md_if #(.ASSOC(ASSOC), .CNT_W(CNT_W)) hit_if ();

    blk_hit_trk_md #(.ASSOC(ASSOC), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .hit_if (hit_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: what the outputs should show after the latest edge.
    bit m_prev_act, m_vld, m_hit, m_wr, m_mh, m_ce;
    int m_way;
    int m_cnt[4];  // 0 rd_hit, 1 wr_hit, 2 rd_miss, 3 wr_miss

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev_act = 0; m_vld = 0; m_hit = 0; m_wr = 0; m_mh = 0; m_ce = 0; m_way = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic model_edge(input bit rd, input bit wr, input logic [ASSOC-1:0] acc,
                              input bit eclr, input bit cclr);
        bit act;
        int idx;
        act = rd | wr;
        if (cclr) begin
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else if (m_vld) begin
            idx = m_wr ? (m_hit ? 1 : 3) : (m_hit ? 0 : 2);
            if (m_cnt[idx] < CNT_MAX) m_cnt[idx]++;
        end
        m_vld = act && !m_prev_act;
        m_hit = act && (acc != 0);
        m_way = 0;
        if (m_hit) for (int i = ASSOC - 1; i >= 0; i--) if (acc[i]) m_way = i;
        m_wr  = wr && !rd;
        m_prev_act = act;
        if (act && $countones(acc) > 1) m_mh = 1; else if (eclr) m_mh = 0;
        if (rd && wr) m_ce = 1; else if (eclr) m_ce = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".hit"}, 32'(hit_if.blk_hit_proc), 32'(m_hit));
        check({tag, ".way"}, 32'(hit_if.hit_way), 32'(m_way));
        check({tag, ".vld"}, 32'(hit_if.res_vld), 32'(m_vld));
        check({tag, ".mh"},  32'(hit_if.multi_hit_err), 32'(m_mh));
        check({tag, ".ce"},  32'(hit_if.cmd_err), 32'(m_ce));
`ifdef BLK_HIT_PERF_CNT_EN
        check({tag, ".rdh"}, 32'(hit_if.rd_hit_cnt),  32'(m_cnt[0]));
        check({tag, ".wrh"}, 32'(hit_if.wr_hit_cnt),  32'(m_cnt[1]));
        check({tag, ".rdm"}, 32'(hit_if.rd_miss_cnt), 32'(m_cnt[2]));
        check({tag, ".wrm"}, 32'(hit_if.wr_miss_cnt), 32'(m_cnt[3]));
`endif
    endtask

    // One clock: drive at negedge, model at posedge, sample 1 ns after it.
    task automatic cyc(input string tag, input bit rd, input bit wr, input logic [ASSOC-1:0] acc,
                       input bit eclr = 0, input bit cclr = 0);
        hit_if.cmd_rd = rd;
        hit_if.cmd_wr = wr;
        hit_if.access_blk_proc = acc;
        hit_if.err_clr = eclr;
`ifdef BLK_HIT_PERF_CNT_EN
        hit_if.cnt_clr = cclr;
`endif
        @(posedge clk);
        model_edge(rd, wr, acc, eclr, cclr);
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int vld_seen;
        rst = 1'b1;
        hit_if.cmd_rd = 0; hit_if.cmd_wr = 0; hit_if.access_blk_proc = '0; hit_if.err_clr = 0;
`ifdef BLK_HIT_PERF_CNT_EN
        hit_if.cnt_clr = 0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        rst = 1'b0;

        // Single read hit on way 2.
        cyc("t1", 1, 0, 4'b0100);
        check("t1.way2", 32'(hit_if.hit_way), 32'd2);
        check("t1.vld", 32'(hit_if.res_vld), 32'd1);
        cyc("t1.drop", 0, 0, 4'b0000);
`ifdef BLK_HIT_PERF_CNT_EN
        check("t1.rdh1", 32'(hit_if.rd_hit_cnt), 32'd1);
`endif

        // Write miss held three cycles: one res_vld pulse.
        vld_seen = 0;
        for (int i = 0; i < 3; i++) begin
            cyc("t2", 0, 1, 4'b0000);
            vld_seen += int'(hit_if.res_vld);
        end
        check("t2.one_pulse", 32'(vld_seen), 32'd1);
        cyc("t2.drop", 0, 0, 4'b0000);
`ifdef BLK_HIT_PERF_CNT_EN
        check("t2.wrm1", 32'(hit_if.wr_miss_cnt), 32'd1);
`endif

        // Multi-way hit: lowest way reported, sticky error until err_clr.
        cyc("t3", 1, 0, 4'b1010);
        check("t3.way1", 32'(hit_if.hit_way), 32'd1);
        cyc("t3.drop", 0, 0, 4'b0000);
        check("t3.sticky", 32'(hit_if.multi_hit_err), 32'd1);
        cyc("t3.clr", 0, 0, 4'b0000, 1);
        check("t3.cleared", 32'(hit_if.multi_hit_err), 32'd0);

        // Illegal rd+wr counts as a read hit.
        cyc("t4", 1, 1, 4'b0001);
        check("t4.ce", 32'(hit_if.cmd_err), 32'd1);
        cyc("t4.drop", 0, 0, 4'b0000);
`ifdef BLK_HIT_PERF_CNT_EN
        check("t4.rdh3", 32'(hit_if.rd_hit_cnt), 32'd3);
        check("t4.wrh0", 32'(hit_if.wr_hit_cnt), 32'd0);
        check("t4.wrm1", 32'(hit_if.wr_miss_cnt), 32'd1);
`endif
        // Clear and new error in the same cycle: set wins.
        cyc("t4.setwin", 1, 1, 4'b0000, 1);
        check("t4.setwin_ce", 32'(hit_if.cmd_err), 32'd1);
        cyc("t4.clr", 0, 0, 4'b0000, 1);

        // Saturation, then clear; clear beats a same-cycle increment.
        for (int i = 0; i < 20; i++) begin
            cyc("t5", 1, 0, 4'b0001);
            cyc("t5.gap", 0, 0, 4'b0000);
        end
`ifdef BLK_HIT_PERF_CNT_EN
        check("t5.sat", 32'(hit_if.rd_hit_cnt), 32'(CNT_MAX));
`endif
        cyc("t5.clr", 0, 0, 4'b0000, 0, 1);
        cyc("t5.req", 1, 0, 4'b0001);
        cyc("t5.clr_inc", 0, 0, 4'b0000, 0, 1);
`ifdef BLK_HIT_PERF_CNT_EN
        check("t5.zero", 32'(hit_if.rd_hit_cnt), 32'd0);
`endif

        // Asynchronous reset mid-request, then a fresh request with cmd still high.
        cyc("t6", 1, 0, 4'b0010);
        #2 rst = 1'b1;
        #1 model_reset();
        check_outputs("t6.async");
        @(negedge clk);
        rst = 1'b0;
        cyc("t6.after", 1, 0, 4'b0010);
        check("t6.vld", 32'(hit_if.res_vld), 32'd1);
        cyc("t6.drop", 0, 0, 4'b0000);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [ASSOC-1:0] acc;
            bit rd, wr, eclr, cclr;
            acc  = ASSOC'($urandom);
            rd   = ($urandom_range(0, 2) == 0);
            wr   = ($urandom_range(0, 2) == 0);
            eclr = ($urandom_range(0, 15) == 0);
            cclr = ($urandom_range(0, 31) == 0);
            cyc("rnd", rd, wr, acc, eclr, cclr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
